// File: rtl/load_use_scoreboard.sv
// rtl/load_use_scoreboard.sv - load-use hazard scoreboard with a LOAD_LAT-1 deep pending-load shift chain
// Optional stall counter output enabled by macro HAZARD_STALL_CNT_EN.
module load_use_scoreboard #(
  parameter int LOAD_LAT  = 2,
  parameter int IGNORE_R0 = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [4:0] rs_i,
  input  logic [4:0] rt_i,
  input  logic       rs_used_i,
  input  logic       rt_used_i,
  input  logic       id_ex_memread_i,
  input  logic [4:0] id_ex_rt_i,
  input  logic       flush_i,
  output logic       pc_stall_o,
  output logic       if_id_stall_o,
  output logic       bubble_o
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt_o
`endif
);

  localparam int NSLOT = LOAD_LAT - 1;

  logic ignore_r0;
  logic ex_valid;
  logic ex_match;
  logic slot_hit;
  logic hazard;
  logic stall;

  assign ignore_r0 = (IGNORE_R0 != 0);

  // A load to r0 (when ignored) is never considered pending, so it neither matches nor enters the chain.
  assign ex_valid = id_ex_memread_i & ~(ignore_r0 & (id_ex_rt_i == 5'd0));
  assign ex_match = ex_valid & ((rs_used_i & (rs_i == id_ex_rt_i)) |
                                (rt_used_i & (rt_i == id_ex_rt_i)));

  generate
    if (NSLOT > 0) begin : g_chain
      logic [NSLOT-1:0] slot_vld_q;
      logic [NSLOT-1:0] slot_vld_d;
      logic [4:0]       slot_reg_q [NSLOT];
      logic [4:0]       slot_reg_d [NSLOT];

      // The chain advances unconditionally: EX and later stages never stall.
      always_comb begin
        slot_vld_d[0] = ex_valid;
        slot_reg_d[0] = id_ex_rt_i;
        for (int k = 1; k < NSLOT; k++) begin
          slot_vld_d[k] = slot_vld_q[k-1];
          slot_reg_d[k] = slot_reg_q[k-1];
        end
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          slot_vld_q <= '0;
          for (int k = 0; k < NSLOT; k++) slot_reg_q[k] <= 5'd0;
        end else begin
          slot_vld_q <= slot_vld_d;
          for (int k = 0; k < NSLOT; k++) slot_reg_q[k] <= slot_reg_d[k];
        end
      end

      always_comb begin
        slot_hit = 1'b0;
        for (int k = 0; k < NSLOT; k++) begin
          if (slot_vld_q[k] &&
              ((rs_used_i && (rs_i == slot_reg_q[k])) ||
               (rt_used_i && (rt_i == slot_reg_q[k]))))
            slot_hit = 1'b1;
        end
      end
    end else begin : g_no_chain
      assign slot_hit = 1'b0;
    end
  endgenerate

  assign hazard        = ex_match | slot_hit;
  assign stall         = hazard & ~flush_i & ~rst_i;
  assign pc_stall_o    = stall;
  assign if_id_stall_o = stall;
  assign bubble_o      = stall;

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) stall_cnt_q <= 32'd0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_load_use_scoreboard.sv
// tb/tb_load_use_scoreboard.sv - directed vector bench for load_use_scoreboard
// Four instances share inputs: LAT2/R0 ignored, LAT2/R0 tracked, LAT1, LAT3.
module tb_load_use_scoreboard;

  logic       clk;
  logic       rst;
  logic [4:0] rs, rt, id_ex_rt;
  logic       rs_used, rt_used, memread, flush;

  logic s2_pc, s2_if, s2_bu;
  logic sz_pc, sz_if, sz_bu;
  logic s1_pc, s1_if, s1_bu;
  logic s3_pc, s3_if, s3_bu;
`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] c2, cz, c1, c3;
  logic [31:0] exp_cnt;
`endif

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  load_use_scoreboard #(.LOAD_LAT(2), .IGNORE_R0(1)) u_l2 (
    .clk_i(clk), .rst_i(rst), .rs_i(rs), .rt_i(rt), .rs_used_i(rs_used), .rt_used_i(rt_used),
    .id_ex_memread_i(memread), .id_ex_rt_i(id_ex_rt), .flush_i(flush),
    .pc_stall_o(s2_pc), .if_id_stall_o(s2_if), .bubble_o(s2_bu)
`ifdef HAZARD_STALL_CNT_EN
    , .stall_cnt_o(c2)
`endif
  );

  load_use_scoreboard #(.LOAD_LAT(2), .IGNORE_R0(0)) u_l2z (
    .clk_i(clk), .rst_i(rst), .rs_i(rs), .rt_i(rt), .rs_used_i(rs_used), .rt_used_i(rt_used),
    .id_ex_memread_i(memread), .id_ex_rt_i(id_ex_rt), .flush_i(flush),
    .pc_stall_o(sz_pc), .if_id_stall_o(sz_if), .bubble_o(sz_bu)
`ifdef HAZARD_STALL_CNT_EN
    , .stall_cnt_o(cz)
`endif
  );

  load_use_scoreboard #(.LOAD_LAT(1), .IGNORE_R0(1)) u_l1 (
    .clk_i(clk), .rst_i(rst), .rs_i(rs), .rt_i(rt), .rs_used_i(rs_used), .rt_used_i(rt_used),
    .id_ex_memread_i(memread), .id_ex_rt_i(id_ex_rt), .flush_i(flush),
    .pc_stall_o(s1_pc), .if_id_stall_o(s1_if), .bubble_o(s1_bu)
`ifdef HAZARD_STALL_CNT_EN
    , .stall_cnt_o(c1)
`endif
  );

  load_use_scoreboard #(.LOAD_LAT(3), .IGNORE_R0(1)) u_l3 (
    .clk_i(clk), .rst_i(rst), .rs_i(rs), .rt_i(rt), .rs_used_i(rs_used), .rt_used_i(rt_used),
    .id_ex_memread_i(memread), .id_ex_rt_i(id_ex_rt), .flush_i(flush),
    .pc_stall_o(s3_pc), .if_id_stall_o(s3_if), .bubble_o(s3_bu)
`ifdef HAZARD_STALL_CNT_EN
    , .stall_cnt_o(c3)
`endif
  );

  // exp bits: {LAT2, LAT2 with r0 tracked, LAT1, LAT3}
  typedef struct {
    logic       rst;
    logic       mr;
    logic [4:0] idrt;
    logic [4:0] rs;
    logic       rsu;
    logic [4:0] rt;
    logic       rtu;
    logic       fl;
    logic [3:0] exp;
  } vec_t;

  localparam int NVEC = 27;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic r, input logic m, input logic [4:0] d,
                              input logic [4:0] s, input logic su, input logic [4:0] t,
                              input logic tu, input logic f, input logic [3:0] e);
    vec_t v;
    v.rst = r; v.mr = m; v.idrt = d; v.rs = s; v.rsu = su;
    v.rt = t; v.rtu = tu; v.fl = f; v.exp = e;
    return v;
  endfunction

  task automatic chk3(input string name, input int idx, input logic [2:0] got, input logic e);
    checks++;
    if (got !== {3{e}}) begin
      errors++;
      $display("FAIL %s vec %0d: {pc,ifid,bubble}=%b required %b", name, idx, got, {3{e}});
    end
  endtask

  task automatic chk_int(input string name, input int got, input int e);
    checks++;
    if (got != e) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, got, e);
    end
  endtask

  task automatic apply(input vec_t v);
    rst = v.rst; memread = v.mr; id_ex_rt = v.idrt; rs = v.rs; rs_used = v.rsu;
    rt = v.rt; rt_used = v.rtu; flush = v.fl;
  endtask

  initial begin
    int n1, n2, n3;
    vecs[0]  = mk(1, 1, 5, 5, 1, 0, 0, 0, 4'b0000);  // reset masks a live hazard
    vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
    vecs[2]  = mk(0, 1, 5, 5, 1, 0, 0, 0, 4'b1111);  // lw $5 ; add rs=5
    vecs[3]  = mk(0, 0, 0, 5, 1, 0, 0, 0, 4'b1101);
    vecs[4]  = mk(0, 0, 0, 5, 1, 0, 0, 0, 4'b0001);
    vecs[5]  = mk(0, 0, 0, 5, 1, 0, 0, 0, 4'b0000);
    vecs[6]  = mk(0, 1, 5, 0, 0, 0, 0, 0, 4'b0000);  // lw $5 ; indep ; user rt=5
    vecs[7]  = mk(0, 0, 0, 0, 0, 5, 1, 0, 4'b1101);
    vecs[8]  = mk(0, 0, 0, 0, 0, 5, 1, 0, 4'b0001);
    vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
    vecs[10] = mk(0, 1, 0, 0, 1, 0, 0, 0, 4'b0100);  // lw $0 ; user rs=0
    vecs[11] = mk(0, 0, 0, 0, 1, 0, 0, 0, 4'b0100);
    vecs[12] = mk(0, 0, 0, 0, 1, 0, 0, 0, 4'b0000);
    vecs[13] = mk(0, 1, 5, 5, 1, 0, 0, 1, 4'b0000);  // flush masks but keeps slot
    vecs[14] = mk(0, 0, 0, 5, 1, 0, 0, 0, 4'b1101);
    vecs[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
    vecs[16] = mk(0, 1, 5, 5, 1, 0, 0, 0, 4'b1111);  // reset in second stall cycle
    vecs[17] = mk(1, 0, 0, 5, 1, 0, 0, 0, 4'b0000);
    vecs[18] = mk(0, 0, 0, 5, 1, 0, 0, 0, 4'b0000);
    vecs[19] = mk(0, 1, 5, 0, 0, 0, 0, 0, 4'b0000);  // lw $5 ; lw $6 ; user rs=5 rt=6
    vecs[20] = mk(0, 1, 6, 0, 0, 0, 0, 0, 4'b0000);
    vecs[21] = mk(0, 0, 0, 5, 1, 6, 1, 0, 4'b1101);
    vecs[22] = mk(0, 0, 0, 5, 1, 6, 1, 0, 4'b0001);
    vecs[23] = mk(0, 0, 0, 5, 1, 6, 1, 0, 4'b0000);
    vecs[24] = mk(0, 1, 7, 7, 0, 3, 1, 0, 4'b0000);  // matching field not used
    vecs[25] = mk(0, 0, 0, 7, 0, 7, 0, 0, 4'b0000);
    vecs[26] = mk(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000);

`ifdef HAZARD_STALL_CNT_EN
    exp_cnt = 32'd0;
`endif
    for (int i = 0; i < NVEC; i++) begin
      apply(vecs[i]);
      @(negedge clk);
      chk3("lat2",    i, {s2_pc, s2_if, s2_bu}, vecs[i].exp[3]);
      chk3("lat2_r0", i, {sz_pc, sz_if, sz_bu}, vecs[i].exp[2]);
      chk3("lat1",    i, {s1_pc, s1_if, s1_bu}, vecs[i].exp[1]);
      chk3("lat3",    i, {s3_pc, s3_if, s3_bu}, vecs[i].exp[0]);
`ifdef HAZARD_STALL_CNT_EN
      if (i > 0) chk_int("stall_cnt_lat2", int'(c2), int'(exp_cnt));
`endif
      @(posedge clk);
`ifdef HAZARD_STALL_CNT_EN
      if (vecs[i].rst) exp_cnt = 32'd0;
      else if (vecs[i].exp[3]) exp_cnt = exp_cnt + 32'd1;
`endif
      #1;
    end

    // Pipeline-style run: load enters ID/EX, a bubble follows while the user waits in IF/ID.
    n1 = 0; n2 = 0; n3 = 0;
    rst = 0; flush = 0; memread = 1; id_ex_rt = 5'd9;
    rs = 5'd9; rs_used = 1; rt = 5'd0; rt_used = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (s1_pc) n1++;
      if (s2_pc) n2++;
      if (s3_pc) n3++;
      @(posedge clk);
      #1;
      memread = 0; id_ex_rt = 5'd0;
    end
    chk_int("stall_len_lat1", n1, 1);
    chk_int("stall_len_lat2", n2, 2);
    chk_int("stall_len_lat3", n3, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_use_scoreboard.md
LOAD_USE_SCOREBOARD -- requirements
Module: load_use_scoreboard

Interface
REQ-001 Parameter LOAD_LAT, default 2: cycles after EX until load data can be forwarded; legal range 1..8.
REQ-002 Parameter IGNORE_R0, default 1: when 1, register 0 never causes a stall.
REQ-003 Port clk_i, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst_i, input, 1: reset, synchronous and active-high.
REQ-005 Port rs_i, input, 5: rs field of the instruction in IF/ID.
REQ-006 Port rt_i, input, 5: rt field of the instruction in IF/ID.
REQ-007 Port rs_used_i / rt_used_i, input, 1 each: the IF/ID instruction reads rs / rt.
REQ-008 Port id_ex_memread_i, input, 1: the ID/EX instruction is a load.
REQ-009 Port id_ex_rt_i, input, 5: destination register of the ID/EX instruction.
REQ-010 Port flush_i, input, 1: the IF/ID instruction is being squashed this cycle.
REQ-011 Port pc_stall_o, input-hold request for PC, output, 1.
REQ-012 Port if_id_stall_o, output, 1: hold the IF/ID register.
REQ-013 Port bubble_o, output, 1: zero control signals entering ID/EX.

Function
REQ-014 The block SHALL hold a shift chain of LOAD_LAT-1 slots, each {valid, reg[4:0]}; with LOAD_LAT=1 the chain is empty.
REQ-015 Each cycle, slot[0] SHALL load {id_ex_memread_i & ~(IGNORE_R0 & id_ex_rt_i==0), id_ex_rt_i}, and slot[k] SHALL load slot[k-1].
REQ-016 The chain SHALL shift every cycle regardless of stall, because EX and later stages always advance.
REQ-017 Source match SHALL be (rs_used_i & rs_i==R) | (rt_used_i & rt_i==R) for a pending register R, with R==0 excluded when IGNORE_R0=1.
REQ-018 Hazard SHALL be true when a source matches id_ex_rt_i while id_ex_memread_i=1, or matches any valid slot.
REQ-019 pc_stall_o, if_id_stall_o and bubble_o SHALL all equal hazard & ~flush_i & ~rst_i, driven combinationally with zero added latency.
REQ-020 A load followed by a dependent instruction SHALL stall exactly LOAD_LAT cycles; at distance d (1..LOAD_LAT) it SHALL stall LOAD_LAT-d+1 cycles.
REQ-021 A bubble in ID/EX (memread=0) SHALL insert an invalid slot, so a stall never extends itself.
REQ-022 Multiple pending loads to different registers SHALL be tracked independently; the stall lasts until no valid match remains.
REQ-023 flush_i=1 SHALL suppress the stall outputs for that cycle only and SHALL NOT clear slots, because older loads still complete.

Reset
REQ-024 On a rising edge with rst_i=1, all slot valid bits SHALL clear to 0.
REQ-025 While rst_i=1, all stall outputs SHALL be 0.
REQ-026 Reset asserted mid-stall SHALL end the stall on the next cycle unless id_ex_memread_i recreates the hazard.

Configuration
REQ-027 With macro HAZARD_STALL_CNT_EN defined, the block SHALL add output stall_cnt_o[31:0] and reset it to 0.
REQ-028 stall_cnt_o SHALL increment by 1 on each edge where pc_stall_o=1, wrapping from 0xFFFFFFFF to 0.
REQ-029 Without HAZARD_STALL_CNT_EN, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-030 LOAD_LAT=2: lw $5 in ID/EX, next instruction add uses rs=5 -> stall outputs 1 for exactly 2 cycles, then 0.
REQ-031 LOAD_LAT=2: lw $5, then an independent instruction, then a user of rt=5 -> 1 stall cycle (slot match only).
REQ-032 IGNORE_R0=1: lw $0, then a user of rs=0 -> no stall; with IGNORE_R0=0 -> 2 stall cycles.
REQ-033 lw $5 in ID/EX with a user of $5 in IF/ID and flush_i=1 -> outputs 0 that cycle; slot[0] still holds {1,5} next cycle.
REQ-034 rst_i=1 during the second stall cycle -> outputs 0 immediately and slots empty after the edge; with HAZARD_STALL_CNT_EN, stall_cnt_o=0.
REQ-035 LOAD_LAT=1 -> stall only on a direct ID/EX match, lasting 1 cycle, with no slots present.
